log2_div_n: RTL and testbench

- Downstream consumer of the hyperbolic-vectoring CORDIC in the Nth-root datapath.
- The CORDIC output z is atanh((m-1)/(m+1))/ln2 in signed Q2.27. This block forms the full base-2 log, L = e + 2·z, where e is the unbiased FP exponent.
- It then divides L by the root degree N with a sequential restoring divider and hands L/N to the exp2 rotation stage.
- Valid/ready handshake on both sides; one operation in flight at a time.

---
 rtl/nthroot_pkg.sv | 23 ++
 rtl/seq_udiv.sv | 84 ++++++++
 rtl/log2_div_n.sv | 137 +++++++++++++
 tb/tb_log2_div_n.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/nthroot_pkg.sv
// Shared definitions for the Nth-root datapath (CORDIC, log2_div_n, exp2 stage).
//   FRAC_W / Z_W : fixed-point format of the CORDIC angle output
//   EXP_W        : signed unbiased FP exponent width
//   N_W          : root-degree width
//   state_e      : control states of log2_div_n
//   ONE_Q        : 1.0 in the shared Q format
package nthroot_pkg;

    localparam int unsigned FRAC_W = 27;
    localparam int unsigned Z_W    = 30;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned N_W    = 5;

    localparam logic signed [63:0] ONE_Q = 64'sd1 <<< FRAC_W;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        DIV,
        DONE
    } state_e;

endpackage

// File: rtl/seq_udiv.sv
// Unsigned sequential restoring divider, one quotient bit per cycle, MSB first.
//   clk, rst    : clock, asynchronous active-high reset
//   start_i     : load dividend, clear remainder/quotient, begin DVD_W steps
//   dividend_i  : unsigned dividend, sampled on start_i
//   divisor_i   : unsigned divisor, must be held stable while busy
//   done_o      : high during the final step cycle
//   quot_o      : quotient including this cycle's bit (complete when done_o)
module seq_udiv #(
    parameter int unsigned DVD_W = 36,
    parameter int unsigned DVS_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             done_o,
    output logic [DVD_W-1:0] quot_o
);

    localparam int unsigned CNT_W = $clog2(DVD_W);

    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVD_W-1:0] quot_q, quot_d;
    logic [DVS_W:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    logic [DVS_W:0]   rem_sh;
    logic             q_bit;
    logic [DVD_W-1:0] quot_step;
    logic [DVS_W:0]   rem_step;

    // Remainder stays below the divisor, so the shifted value fits in DVS_W+1 bits.
    always_comb begin
        rem_sh    = (rem_q << 1) | {{DVS_W{1'b0}}, dvd_q[DVD_W-1]};
        q_bit     = (rem_sh >= {1'b0, divisor_i});
        rem_step  = q_bit ? (rem_sh - {1'b0, divisor_i}) : rem_sh;
        quot_step = (quot_q << 1) | {{(DVD_W-1){1'b0}}, q_bit};
    end

    always_comb begin
        dvd_d  = dvd_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            dvd_d  = dividend_i;
            quot_d = '0;
            rem_d  = '0;
            cnt_d  = CNT_W'(DVD_W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            dvd_d  = dvd_q << 1;
            quot_d = quot_step;
            rem_d  = rem_step;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end
        end
    end

    assign done_o = busy_q && (cnt_q == '0);
    assign quot_o = quot_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/log2_div_n.sv
// Forms L = e + 2*z (base-2 log of the Nth-root operand) and divides it by N.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake, one operation in flight
//   z_in                : signed Q2.27 CORDIC angle, atanh(y/x)/ln2
//   exp_in              : signed unbiased exponent
//   n_in                : unsigned root degree (0 flags err)
//   out_valid/out_ready : output handshake, result held until taken
//   q_out               : signed Q8.27 L/N, truncated toward zero
//   err                 : root degree was zero
module log2_div_n #(
    parameter int unsigned Z_W    = nthroot_pkg::Z_W,
    parameter int unsigned FRAC_W = nthroot_pkg::FRAC_W,
    parameter int unsigned EXP_W  = nthroot_pkg::EXP_W,
    parameter int unsigned N_W    = nthroot_pkg::N_W,
    localparam int unsigned L_W   = EXP_W + FRAC_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Z_W-1:0]   z_in,
    input  logic [EXP_W-1:0] exp_in,
    input  logic [N_W-1:0]   n_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [L_W-1:0]   q_out,
    output logic             err
);

    import nthroot_pkg::*;

    state_e           state_q, state_d;
    logic [Z_W-1:0]   z_q, z_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [N_W-1:0]   n_q, n_d;
    logic             sign_q, sign_d;
    logic [L_W-1:0]   q_out_q, q_out_d;
    logic             err_q, err_d;

    logic [L_W-1:0]   l_val;
    logic [L_W-1:0]   l_mag;
    logic [L_W-1:0]   quot;
    logic             div_start;
    logic             div_done;

    // Over the legal exponent range L stays within +/-135 in Q8.27, so no overflow.
    always_comb begin
        l_val = ({{(L_W-EXP_W){exp_q[EXP_W-1]}}, exp_q} << FRAC_W)
              + ({{(L_W-Z_W){z_q[Z_W-1]}}, z_q} << 1);
        l_mag = l_val[L_W-1] ? (~l_val + 1'b1) : l_val;
    end

    // Divider loads on the PREP edge, so DIV lasts exactly L_W cycles.
    assign div_start = (state_q == PREP) && (n_q != '0);

    seq_udiv #(
        .DVD_W (L_W),
        .DVS_W (N_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (l_mag),
        .divisor_i  (n_q),
        .done_o     (div_done),
        .quot_o     (quot)
    );

    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        exp_d   = exp_q;
        n_d     = n_q;
        sign_d  = sign_q;
        q_out_d = q_out_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    z_d     = z_in;
                    exp_d   = exp_in;
                    n_d     = n_in;
                    state_d = PREP;
                end
            end
            PREP: begin
                sign_d = l_val[L_W-1];
                if (n_q == '0) begin
                    q_out_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    err_d   = 1'b0;
                    state_d = DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    q_out_d = sign_q ? (~quot + 1'b1) : quot;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign q_out     = q_out_q;
    assign err       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            z_q     <= '0;
            exp_q   <= '0;
            n_q     <= '0;
            sign_q  <= 1'b0;
            q_out_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            exp_q   <= exp_d;
            n_q     <= n_d;
            sign_q  <= sign_d;
            q_out_q <= q_out_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_log2_div_n.sv
module tb_log2_div_n;

    localparam int L_W = 36;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] z_in = '0;
    logic [7:0]  exp_in = '0;
    logic [4:0]  n_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [35:0] q_out;
    logic        err;

    log2_div_n dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z_in      (z_in),
        .exp_in    (exp_in),
        .n_in      (n_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_out     (q_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] q;
        logic        e;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic rdy_rand = 1'b0;
    logic rdy_force = 1'b1;
    logic ov_prev = 1'b0;

    always @(posedge clk) cyc++;

    // out_ready changes just after the rising edge, away from sampling points.
    always @(posedge clk) begin
        #2;
        out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_force;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: L = e*2^27 + 2*z as an integer, then integer division (toward zero).
    function automatic logic [35:0] ref_q(input int e, input int z, input int n);
        longint l;
        l = longint'(e) * (longint'(1) << 27) + 2 * longint'(z);
        if (n == 0) return '0;
        return 36'(l / longint'(n));
    endfunction

    task automatic send(input int e, input int z, input int n);
        int   t = 0;
        exp_t x;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("send_timeout", 64'(in_ready), 64'd1);
            return;
        end
        exp_in   = e[7:0];
        z_in     = z[29:0];
        n_in     = n[4:0];
        in_valid = 1'b1;
        x.q   = ref_q(e, z, n);
        x.e   = (n == 0);
        x.acc = cyc + 1;
        sb.push_back(x);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("done_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: latency on each rise of out_valid, data on each accepted result.
    always @(negedge clk) begin
        if (rst) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev && sb.size() != 0) begin
                chk("latency", 64'(cyc + 1 - sb[0].acc), sb[0].e ? 64'd2 : 64'(L_W + 2));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'(q_out), 64'hdead);
                end else begin
                    chk("q_out", 64'(q_out), 64'(sb[0].q));
                    chk("err", 64'(err), 64'(sb[0].e));
                    void'(sb.pop_front());
                end
            end
            ov_prev = out_valid;
        end
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_q_out", 64'(q_out), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;

        // Directed cases
        send(3, 0, 3);                      wait_done();
        send(-6, 0, 2);                     wait_done();
        send(0, 32'h2000000, 1);            wait_done();
        send(-1, 32'h0800000, 3);           wait_done();
        send(5, 123, 0);                    wait_done();
        send(2, 32'h100, 5);                wait_done();
        send(127, (1 << 29) - 1, 1);        wait_done();
        send(-126, -(1 << 29), 31);         wait_done();
        send(-126, -(1 << 29), 1);          wait_done();

        // Backpressure in DONE, plus an input offered while busy
        rdy_force = 1'b0;
        send(3, 0, 3);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("bp_reach_done", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                exp_in = 8'd0; z_in = '0; n_in = 5'd1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_q_out", 64'(q_out), 64'h008000000);
            chk("bp_err", 64'(err), 64'd0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        rdy_force = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        repeat (50) @(negedge clk);
        chk("bp_no_capture", 64'(in_ready), 64'd1);

        // Asynchronous reset in the middle of a division
        send(3, 0, 3);
        repeat (16) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_q_out", 64'(q_out), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        send(3, 0, 3);                      wait_done();

        // Randomised operations with random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int e, z, n;
            e = int'($urandom_range(0, 253)) - 126;
            z = int'($urandom) >>> 2;
            n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 31));
            send(e, z, n);
            if ($urandom_range(0, 1) == 1) wait_done();
        end
        wait_done();
        rdy_rand = 1'b0;
        repeat (5) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
